// File: rtl/axi_burst_pkg.sv
// Shared types, AXI constants and the burst-chunking rule for the burst read master.
package axi_burst_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Beats in the next burst: limited by what is left, by MAX_BURST and by the 4 KB page end.
  function automatic int unsigned chunk_len(input int unsigned remaining,
                                            input int unsigned word_addr,
                                            input int unsigned max_burst,
                                            input int unsigned off);
    int unsigned wpk, to4k, c;
    wpk  = 32'd4096 >> off;
    to4k = wpk - (word_addr & (wpk - 32'd1));
    c    = remaining;
    if (max_burst < c) c = max_burst;
    if (to4k < c)      c = to4k;
    return c;
  endfunction

endpackage

// File: rtl/axi_mem_burst_rd.sv
// AXI4 burst read master: splits one word-addressed request into INCR bursts
// (<= MAX_BURST beats, never crossing 4 KB) and streams beats to the client.
module axi_mem_burst_rd import axi_burst_pkg::*; #(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 32,
  parameter int AXI4_ID_WIDTH   = 16,
  parameter int AXI4_USER_WIDTH = 10,
  parameter int AR_ID           = 0,
  parameter int MAX_BURST       = 16,
  parameter int LEN_WIDTH       = 12,
  localparam int OFF            = $clog2(AXI4_DATA_WIDTH / 8),
  localparam int WAW            = AXI4_ADDR_WIDTH - OFF
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  output logic [AXI4_ID_WIDTH-1:0]   ARID_o,
  output logic [AXI4_ADDR_WIDTH-1:0] ARADDR_o,
  output logic [7:0]                 ARLEN_o,
  output logic [2:0]                 ARSIZE_o,
  output logic [1:0]                 ARBURST_o,
  output logic                       ARLOCK_o,
  output logic [3:0]                 ARCACHE_o,
  output logic [2:0]                 ARPROT_o,
  output logic [3:0]                 ARREGION_o,
  output logic [AXI4_USER_WIDTH-1:0] ARUSER_o,
  output logic [3:0]                 ARQOS_o,
  output logic                       ARVALID_o,
  input  logic                       ARREADY_i,
  input  logic [AXI4_ID_WIDTH-1:0]   RID_i,
  input  logic [AXI4_DATA_WIDTH-1:0] RDATA_i,
  input  logic [1:0]                 RRESP_i,
  input  logic                       RLAST_i,
  input  logic [AXI4_USER_WIDTH-1:0] RUSER_i,
  input  logic                       RVALID_i,
  output logic                       RREADY_o,
  input  logic                       rd_req_i,
  input  logic [WAW-1:0]             rd_word_addr_i,
  input  logic [LEN_WIDTH-1:0]       rd_len_i,
  output logic                       rd_gnt_o,
  output logic [AXI4_DATA_WIDTH-1:0] rd_data_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic                       rd_last_o,
  output logic                       rd_done_o,
  output logic [1:0]                 rd_err_o
);

  state_t               state_q;
  logic [WAW-1:0]       addr_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [8:0]           chunk_q;
  logic [8:0]           beat_cnt_q;
  logic                 arvalid_q;
  logic                 done_q;
  logic [1:0]           err_q;
  logic                 proto_q;
  logic                 resp_q;

  logic                 in_data, r_hs, last_beat, burst_end;
  logic                 proto_nxt, resp_nxt;
  logic [LEN_WIDTH-1:0] rem_dec, rem_nxt, len_eff;
  logic [WAW-1:0]       addr_nxt;

  // ID and user sideband of R are not used: only one AR is ever outstanding.
  logic unused_ok;
  assign unused_ok = ^{RID_i, RUSER_i, RRESP_i[0]};

  assign ARID_o     = AXI4_ID_WIDTH'(AR_ID);
  assign ARADDR_o   = {addr_q, {OFF{1'b0}}};
  assign ARLEN_o    = 8'(chunk_q - 9'd1);
  assign ARSIZE_o   = 3'(OFF);
  assign ARBURST_o  = BURST_INCR;
  assign ARLOCK_o   = 1'b0;
  assign ARCACHE_o  = '0;
  assign ARPROT_o   = '0;
  assign ARREGION_o = '0;
  assign ARUSER_o   = '0;
  assign ARQOS_o    = '0;
  assign ARVALID_o  = arvalid_q;

  assign in_data    = (state_q == S_DATA);
  assign RREADY_o   = in_data & rd_ready_i;
  assign rd_valid_o = in_data & RVALID_i;
  assign rd_data_o  = RDATA_i;
  assign rd_gnt_o   = (state_q == S_IDLE) & rd_req_i;
  assign rd_done_o  = done_q;
  assign rd_err_o   = err_q;

  assign r_hs      = in_data & RVALID_i & rd_ready_i;
  assign last_beat = (beat_cnt_q == 9'd1);
  assign burst_end = r_hs & (RLAST_i | last_beat);

  // An early RLAST drops the rest of the burst: the unfetched beats are written off
  // from the remaining count and skipped in the address, keeping both in step.
  assign rem_dec   = RLAST_i ? LEN_WIDTH'(beat_cnt_q) : LEN_WIDTH'(1);
  assign rem_nxt   = rem_q - rem_dec;
  assign addr_nxt  = addr_q + WAW'(rem_dec);
  assign proto_nxt = proto_q | (RLAST_i != last_beat);
  assign resp_nxt  = resp_q | RRESP_i[1];
  assign len_eff   = (rd_len_i == '0) ? LEN_WIDTH'(1) : rd_len_i;

  // Final beat of the request: either the last counted beat or an early RLAST in the last burst.
  assign rd_last_o = rd_valid_o &
                     ((rem_q == LEN_WIDTH'(1)) | (RLAST_i & (rem_q == LEN_WIDTH'(beat_cnt_q))));

  // Request/burst sequencer; chunk_q is computed on the transition into S_ADDR so AR is stable.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      chunk_q    <= '0;
      beat_cnt_q <= '0;
      arvalid_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      proto_q    <= 1'b0;
      resp_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (rd_req_i) begin
          addr_q    <= rd_word_addr_i;
          rem_q     <= len_eff;
          proto_q   <= 1'b0;
          resp_q    <= 1'b0;
          chunk_q   <= 9'(chunk_len(32'(len_eff), 32'(rd_word_addr_i), MAX_BURST, OFF));
          arvalid_q <= 1'b1;
          state_q   <= S_ADDR;
        end
        S_ADDR: if (ARREADY_i) begin
          arvalid_q  <= 1'b0;
          beat_cnt_q <= chunk_q;
          state_q    <= S_DATA;
        end
        S_DATA: if (r_hs) begin
          beat_cnt_q <= beat_cnt_q - 9'd1;
          addr_q     <= addr_nxt;
          rem_q      <= rem_nxt;
          proto_q    <= proto_nxt;
          resp_q     <= resp_nxt;
          if (burst_end) begin
            if (rem_nxt == '0) begin
              done_q  <= 1'b1;
              err_q   <= {proto_nxt, resp_nxt};
              state_q <= S_DONE;
            end else begin
              chunk_q   <= 9'(chunk_len(32'(rem_nxt), 32'(addr_nxt), MAX_BURST, OFF));
              arvalid_q <= 1'b1;
              state_q   <= S_ADDR;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          err_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_burst_rd.sv
// Bench for axi_mem_burst_rd: table of directed requests against a small AXI slave
// and client model, plus a hand-written mid-burst reset sequence.
module tb_axi_mem_burst_rd;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  logic [15:0] ARID_o;
  logic [31:0] ARADDR_o;
  logic [7:0]  ARLEN_o;
  logic [2:0]  ARSIZE_o;
  logic [1:0]  ARBURST_o;
  logic        ARLOCK_o;
  logic [3:0]  ARCACHE_o;
  logic [2:0]  ARPROT_o;
  logic [3:0]  ARREGION_o;
  logic [9:0]  ARUSER_o;
  logic [3:0]  ARQOS_o;
  logic        ARVALID_o, ARREADY_i;
  logic [15:0] RID_i;
  logic [31:0] RDATA_i;
  logic [1:0]  RRESP_i;
  logic        RLAST_i;
  logic [9:0]  RUSER_i;
  logic        RVALID_i, RREADY_o;
  logic        rd_req_i = 1'b0;
  logic [29:0] rd_word_addr_i = '0;
  logic [11:0] rd_len_i = '0;
  logic        rd_gnt_o, rd_valid_o, rd_ready_i, rd_last_o, rd_done_o;
  logic [31:0] rd_data_o;
  logic [1:0]  rd_err_o;

  axi_mem_burst_rd dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID_o(ARID_o), .ARADDR_o(ARADDR_o), .ARLEN_o(ARLEN_o), .ARSIZE_o(ARSIZE_o),
    .ARBURST_o(ARBURST_o), .ARLOCK_o(ARLOCK_o), .ARCACHE_o(ARCACHE_o), .ARPROT_o(ARPROT_o),
    .ARREGION_o(ARREGION_o), .ARUSER_o(ARUSER_o), .ARQOS_o(ARQOS_o),
    .ARVALID_o(ARVALID_o), .ARREADY_i(ARREADY_i),
    .RID_i(RID_i), .RDATA_i(RDATA_i), .RRESP_i(RRESP_i), .RLAST_i(RLAST_i), .RUSER_i(RUSER_i),
    .RVALID_i(RVALID_i), .RREADY_o(RREADY_o),
    .rd_req_i(rd_req_i), .rd_word_addr_i(rd_word_addr_i), .rd_len_i(rd_len_i),
    .rd_gnt_o(rd_gnt_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i), .rd_last_o(rd_last_o), .rd_done_o(rd_done_o), .rd_err_o(rd_err_o)
  );

  typedef struct {
    string nm;
    int addr, len, ar_delay, tog, err_beat, early_beat;
    int exp_nar, exp_a0, exp_l0, exp_aL, exp_lL, exp_beats, exp_err;
  } vec_t;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // slave/client model configuration and statistics
  int  ar_delay = 0, err_beat = 0, early_beat = 0, base_byte = 0;
  bit  tog = 1'b0;
  bit  slv_busy = 1'b0, ar_go;
  int  ar_wait = 0, beats_left = 0, req_beats = 0, last_cnt = 0, last_at = 0;
  int  done_cnt = 0, data_bad = 0, ar_unstable = 0, mirror_bad = 0;
  logic [31:0] cur, ar_a;
  logic [7:0]  ar_l;
  logic [1:0]  done_err = '0;
  logic [31:0] ar_a_log[$];
  int          ar_l_log[$];

  function automatic logic [31:0] pat(input logic [31:0] b);
    return 32'hD00D_0000 ^ b;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // AXI slave + client: drive on the falling edge, observe the coming handshakes 1 ns later.
  initial begin
    rd_ready_i = 1'b1; ARREADY_i = 1'b0; RVALID_i = 1'b0; RLAST_i = 1'b0;
    RRESP_i = '0; RDATA_i = '0; RID_i = '0; RUSER_i = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        slv_busy = 1'b0; ar_wait = 0; ARREADY_i = 1'b0;
        RVALID_i = 1'b0; RLAST_i = 1'b0; RRESP_i = '0;
      end else begin
        rd_ready_i = tog ? ~rd_ready_i : 1'b1;
        RVALID_i = 1'b0; RLAST_i = 1'b0; RRESP_i = '0;
        if (slv_busy) begin
          RVALID_i = 1'b1;
          RDATA_i  = pat(cur);
          RLAST_i  = (beats_left == 1) || (req_beats + 1 == early_beat);
          RRESP_i  = (req_beats + 1 == err_beat) ? 2'b10 : 2'b00;
        end
        ARREADY_i = 1'b0;
        ar_go = 1'b0;
        if (!slv_busy) begin
          if (ARVALID_o) begin
            if (ar_wait == 0) begin ar_a = ARADDR_o; ar_l = ARLEN_o; end
            else if (ARADDR_o != ar_a || ARLEN_o != ar_l) ar_unstable++;
            if (ar_wait >= ar_delay) begin ARREADY_i = 1'b1; ar_go = 1'b1; ar_wait = 0; end
            else ar_wait++;
          end else if (ar_wait != 0) begin
            ar_unstable++;
            ar_wait = 0;
          end
        end
        #1;
        if (slv_busy) begin
          if (RREADY_o != rd_ready_i || rd_valid_o != 1'b1) mirror_bad++;
          if (RREADY_o) begin
            if (rd_data_o != pat(32'(base_byte + 4 * req_beats))) data_bad++;
            if (rd_last_o) begin last_cnt++; last_at = req_beats + 1; end
            req_beats++;
            beats_left--;
            cur = cur + 32'd4;
            if (RLAST_i) slv_busy = 1'b0;
          end
        end else if (rd_valid_o || rd_last_o || RREADY_o) mirror_bad++;
        if (ar_go) begin
          ar_a_log.push_back(ARADDR_o);
          ar_l_log.push_back(int'(ARLEN_o));
          slv_busy   = 1'b1;
          beats_left = int'(ARLEN_o) + 1;
          cur        = ARADDR_o;
        end
        if (rd_done_o) begin done_cnt++; done_err = rd_err_o; end
      end
    end
  end

  function automatic vec_t mk(input string nm, input int addr, input int len, input int dly,
                              input int tg, input int eb, input int lb, input int nar,
                              input int a0, input int l0, input int aL, input int lL,
                              input int beats, input int err);
    vec_t v;
    v.nm = nm; v.addr = addr; v.len = len; v.ar_delay = dly; v.tog = tg;
    v.err_beat = eb; v.early_beat = lb; v.exp_nar = nar; v.exp_a0 = a0; v.exp_l0 = l0;
    v.exp_aL = aL; v.exp_lL = lL; v.exp_beats = beats; v.exp_err = err;
    return v;
  endfunction

  task automatic clear_stats();
    req_beats = 0; last_cnt = 0; last_at = 0; done_cnt = 0; data_bad = 0;
    ar_unstable = 0; mirror_bad = 0; done_err = '0;
    ar_a_log.delete(); ar_l_log.delete();
  endtask

  task automatic start_req(input int addr, input int len, input string nm);
    int got = 0;
    @(negedge ACLK);
    rd_req_i = 1'b1; rd_word_addr_i = 30'(addr); rd_len_i = 12'(len);
    for (int c = 0; c < 50 && got == 0; c++) begin
      #2;
      if (rd_gnt_o) got = 1;
      else @(negedge ACLK);
    end
    chk({nm, "_gnt"}, longint'(got), 1);
    @(posedge ACLK); #1;
    chk({nm, "_gnt_pulse"}, longint'(rd_gnt_o), 0);
    @(negedge ACLK);
    rd_req_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int c = 0;
    int n;
    ar_delay = v.ar_delay; tog = (v.tog != 0); err_beat = v.err_beat;
    early_beat = v.early_beat; base_byte = v.addr * 4;
    clear_stats();
    start_req(v.addr, v.len, v.nm);
    while (done_cnt == 0 && c < 3000) begin @(posedge ACLK); c++; end
    chk({v.nm, "_done_seen"}, longint'(done_cnt != 0), 1);
    repeat (3) @(posedge ACLK);
    tog = 1'b0;
    n = ar_a_log.size();
    chk({v.nm, "_done_once"}, longint'(done_cnt), 1);
    chk({v.nm, "_num_ar"}, longint'(n), longint'(v.exp_nar));
    chk({v.nm, "_araddr_first"}, longint'(n > 0 ? ar_a_log[0] : 32'hFFFF_FFFF), longint'(v.exp_a0));
    chk({v.nm, "_arlen_first"}, longint'(n > 0 ? ar_l_log[0] : -1), longint'(v.exp_l0));
    chk({v.nm, "_araddr_last"}, longint'(n > 0 ? ar_a_log[n-1] : 32'hFFFF_FFFF), longint'(v.exp_aL));
    chk({v.nm, "_arlen_last"}, longint'(n > 0 ? ar_l_log[n-1] : -1), longint'(v.exp_lL));
    chk({v.nm, "_beats"}, longint'(req_beats), longint'(v.exp_beats));
    chk({v.nm, "_last_count"}, longint'(last_cnt), 1);
    chk({v.nm, "_last_beat"}, longint'(last_at), longint'(v.exp_beats));
    chk({v.nm, "_err"}, longint'(done_err), longint'(v.exp_err));
    chk({v.nm, "_data_order"}, longint'(data_bad), 0);
    chk({v.nm, "_ar_stable"}, longint'(ar_unstable), 0);
    chk({v.nm, "_rready_mirror"}, longint'(mirror_bad), 0);
  endtask

  vec_t vt[9];

  initial begin
    int c;
    vt[0] = mk("single",  'h10,  1, 0, 0, 0, 0, 1, 'h40,   0, 'h40,    0,  1, 0);
    vt[1] = mk("chunk40", 'h0,  40, 0, 0, 0, 0, 3, 'h0,   15, 'h80,    7, 40, 0);
    vt[2] = mk("split4k", 'h3FE, 4, 0, 0, 0, 0, 2, 'hFF8,  1, 'h1000,  1,  4, 0);
    vt[3] = mk("backpr",  'h100, 5, 3, 1, 0, 0, 1, 'h400,  4, 'h400,   4,  5, 0);
    vt[4] = mk("slverr",  'h20,  4, 0, 0, 2, 0, 1, 'h80,   3, 'h80,    3,  4, 1);
    vt[5] = mk("early",   'h40,  4, 0, 0, 0, 3, 1, 'h100,  3, 'h100,   3,  3, 2);
    vt[6] = mk("len0",    'h5,   0, 0, 0, 0, 0, 1, 'h14,   0, 'h14,    0,  1, 0);
    vt[7] = mk("mix4k",   'h3F8,20, 2, 1, 0, 0, 2, 'hFE0,  7, 'h1000, 11, 20, 0);
    vt[8] = mk("err2nd",  'h0,  18, 1, 0,17, 0, 2, 'h0,   15, 'h40,    1, 18, 1);

    // reset state
    #12;
    chk("rst_arvalid", longint'(ARVALID_o), 0);
    chk("rst_rready",  longint'(RREADY_o), 0);
    chk("rst_gnt",     longint'(rd_gnt_o), 0);
    chk("rst_valid",   longint'(rd_valid_o), 0);
    chk("rst_done",    longint'(rd_done_o), 0);
    chk("rst_err",     longint'(rd_err_o), 0);
    chk("rst_arburst", longint'(ARBURST_o), 1);
    chk("rst_arsize",  longint'(ARSIZE_o), 2);
    @(negedge ACLK); #3;
    ARESET = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    // reset in the middle of a data burst, then a fresh request
    ar_delay = 0; tog = 1'b0; err_beat = 0; early_beat = 0; base_byte = 'h800;
    clear_stats();
    start_req('h200, 8, "midrst");
    c = 0;
    while (req_beats < 2 && c < 200) begin @(posedge ACLK); c++; end
    chk("midrst_in_data", longint'(req_beats >= 2), 1);
    @(negedge ACLK); #3;
    ARESET = 1'b1;
    #1;
    chk("midrst_arvalid", longint'(ARVALID_o), 0);
    chk("midrst_rready",  longint'(RREADY_o), 0);
    chk("midrst_valid",   longint'(rd_valid_o), 0);
    chk("midrst_last",    longint'(rd_last_o), 0);
    chk("midrst_done",    longint'(rd_done_o), 0);
    chk("midrst_err",     longint'(rd_err_o), 0);
    repeat (2) @(negedge ACLK);
    #3;
    ARESET = 1'b0;
    run_vec(mk("postrst", 'h30, 3, 0, 0, 0, 0, 1, 'hC0, 2, 'hC0, 2, 3, 0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/axi_mem_burst_rd.md
Name: axi_mem_burst_rd

Overview:
- AXI4 read master that turns one word-addressed request of N beats into one or more INCR bursts.
- Each burst is limited to MAX_BURST beats and never crosses a 4 KB boundary.
- Read data is streamed to the client with valid/ready backpressure.
- Replaces the single-word read port in the user plugin for DMA-style bulk reads; adds error reporting and protocol checking.

Parameters:
AXI4_ADDR_WIDTH, 32, AXI address width
AXI4_DATA_WIDTH, 32, data width; 32 or 64 only
AXI4_ID_WIDTH, 16, ID width
AXI4_USER_WIDTH, 10, user width
AR_ID, 0, constant driven on ARID_o
MAX_BURST, 16, max beats per AXI burst; 1..256
LEN_WIDTH, 12, width of the request length field (beats)

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
ARID_o/ARADDR_o/ARLEN_o/ARSIZE_o/ARBURST_o/ARLOCK_o/ARCACHE_o/ARPROT_o/ARREGION_o/ARUSER_o/ARQOS_o  out  AXI4 widths  AR payload
ARVALID_o  out  1  AR valid
ARREADY_i  in  1  AR ready
RID_i/RDATA_i/RRESP_i/RLAST_i/RUSER_i  in  AXI4 widths  R payload
RVALID_i  in  1  R valid
RREADY_o  out  1  R ready
rd_req_i  in  1  request; held with address/length until rd_gnt_o
rd_word_addr_i  in  AXI4_ADDR_WIDTH-OFF  word address; OFF=log2(DATA_WIDTH/8)
rd_len_i  in  LEN_WIDTH  beats; 0 is treated as 1
rd_gnt_o  out  1  one-cycle accept pulse
rd_data_o  out  DATA_WIDTH  beat data (=RDATA_i)
rd_valid_o  out  1  beat valid (=RVALID_i in S_DATA)
rd_ready_i  in  1  client ready
rd_last_o  out  1  final beat of whole request
rd_done_o  out  1  one-cycle pulse after final beat handshake
rd_err_o  out  2  {proto_err, resp_err}; valid with rd_done_o

Behaviour:
- Reset: FSM=S_IDLE; ARVALID_o=0, rd_gnt_o=0, rd_done_o=0, rd_err_o=0, RREADY_o=0, rd_valid_o=0; all counters/registers cleared. Reset mid-burst abandons the transaction; the slave must be reset with it.
- Fixed AR fields:
  - ARSIZE=OFF, ARBURST=01 (INCR), ARID=AR_ID.
  - All other AR fields 0.
  - ARADDR={cur_word_addr, OFF zeros}.
- S_IDLE:
  - When rd_req_i: pulse rd_gnt_o in the same cycle.
  - Latch addr and remaining=max(rd_len_i,1); clear error flags; go to S_ADDR.
- S_ADDR:
  - chunk=min(remaining, MAX_BURST, words_to_4k); words_to_4k = 4096/bytes_per_word - addr mod (4096/bytes_per_word).
  - chunk is registered on entry, so it is stable while ARVALID_o=1; ARLEN_o=chunk-1.
  - ARVALID_o=1 until ARREADY_i; then go to S_DATA with beat_cnt=chunk.
  - ARVALID is never withdrawn before the handshake.
- S_DATA:
  - RREADY_o=rd_ready_i and rd_valid_o=RVALID_i (combinational pass-through, no buffering).
  - On each R handshake: beat_cnt--, addr++, remaining--.
  - resp_err |= RRESP_i[1] (SLVERR or DECERR).
  - proto_err |= (RLAST_i != (beat_cnt==1)).
  - On the handshake with RLAST_i or beat_cnt==1: if remaining becomes 0, go to S_DONE; else go to S_ADDR.
  - An early RLAST ends the burst; its missing beats are not re-fetched, and remaining is reduced by the shortfall.
  - rd_last_o = RVALID_i & (remaining==1 | early RLAST on final chunk).
- S_DONE: rd_done_o=1 with rd_err_o for one cycle, then S_IDLE. rd_gnt_o cannot assert here; the minimum gap between requests is 1 cycle.
- Only one AR is outstanding at a time; RID_i and RUSER_i are ignored.
- All data beats are forwarded to the client even after an error.

Decomposition:
- Package axi_burst_pkg: state enum (S_IDLE, S_ADDR, S_DATA, S_DONE), AXI burst/resp constants (BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR), function chunk_len(remaining, addr, MAX_BURST, OFF).
- Single module, no sub-module. The chunk calculation lives in the package function so the bench can reuse it as a reference model.

Test Plan:
- Single beat: addr word 0x10, len 1, ARREADY immediate → ARADDR=0x40, ARLEN=0; one beat with rd_last_o=1; rd_done_o with rd_err_o=0.
- Chunking (MAX_BURST=16): word 0x0, len 40 → three ARs: ARADDR 0x0/0x40/0x80 with ARLEN 15/15/7; 40 beats delivered; rd_last_o only on beat 40.
- 4 KB split: word 0x3FE (byte 0xFF8), len 4 → AR 0xFF8 ARLEN=1, then AR 0x1000 ARLEN=1.
- Backpressure: rd_ready_i toggles 1/0 every cycle, ARREADY delayed 3 cycles → RREADY_o mirrors rd_ready_i; ARVALID_o held with stable ARADDR; data order intact.
- Errors: RRESP=SLVERR on beat 2 of 4 → rd_err_o=01. RLAST on beat 3 of ARLEN=3 → rd_err_o[1]=1, done without hang.
- Reset: assert ARESET during S_DATA → outputs return to reset values immediately; a new request after release works normally.
